// File: rtl/signed_seq_div.sv
// Signed sequential divider: restoring shift/subtract on operand magnitudes,
// one quotient bit per clock, followed by a single sign-fixup cycle.
module signed_seq_div #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ITER = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             neg_dd_q, neg_dd_d;
    logic             neg_dv_q, neg_dv_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   trial;

    // Unsigned magnitude; the most-negative value maps to 2^(WIDTH-1) exactly.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + ONE) : x;
    endfunction

    // A < M <= 2^(WIDTH-1), so the shifted partial remainder always fits.
    assign trial = {a_q, q_q[WIDTH-1]} - {1'b0, m_q};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        q_d         = q_q;
        m_d         = m_q;
        neg_dd_d    = neg_dd_q;
        neg_dv_d    = neg_dv_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dz_d        = dz_q;
        ovf_d       = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d      = '0;
                    q_d      = mag(dividend);
                    m_d      = mag(divisor);
                    neg_dd_d = dividend[WIDTH-1];
                    neg_dv_d = divisor[WIDTH-1];
                    cnt_d    = CW'(WIDTH);
                    dz_d     = 1'b0;
                    ovf_d    = 1'b0;
                    state_d  = ITER;
                end
            end
            ITER: begin
                if (m_q == '0) begin
                    // Q still holds |dividend|; re-signing it restores the dividend.
                    quotient_d  = '1;
                    remainder_d = neg_dd_q ? (~q_q + ONE) : q_q;
                    dz_d        = 1'b1;
                    state_d     = DONE;
                end else begin
                    a_d   = trial[WIDTH] ? {a_q[WIDTH-2:0], q_q[WIDTH-1]} : trial[WIDTH-1:0];
                    q_d   = {q_q[WIDTH-2:0], ~trial[WIDTH]};
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                quotient_d  = (neg_dd_q ^ neg_dv_q) ? (~q_q + ONE) : q_q;
                remainder_d = neg_dd_q ? (~a_q + ONE) : a_q;
                ovf_d       = neg_dd_q & neg_dv_q & (m_q == ONE) & (q_q == MOST_NEG);
                state_d     = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            q_q         <= '0;
            m_q         <= '0;
            neg_dd_q    <= 1'b0;
            neg_dv_q    <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dz_q        <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            q_q         <= q_d;
            m_q         <= m_d;
            neg_dd_q    <= neg_dd_d;
            neg_dv_q    <= neg_dv_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dz_q        <= dz_d;
            ovf_q       <= ovf_d;
        end
    end

    assign busy        = (state_q == ITER) || (state_q == FIX);
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dz_q;
    assign overflow    = ovf_q;

endmodule
